// File: rtl/flash_capture_pkg.sv
// Shared definitions for the flash capture path.
//   lane_order_t : order in which the lanes of one flash word are presented
//   lane_select  : maps a sequence position to a physical lane number
package flash_capture_pkg;

    typedef enum logic {
        LANE_LOW_FIRST,
        LANE_HIGH_FIRST
    } lane_order_t;

    // Physical lane for sequence position cnt (0 .. lanes-1) under the given
    // order. The flash write path uses the same mapping, which keeps the two
    // directions consistent.
    function automatic int unsigned lane_select(
        input lane_order_t order,
        input int unsigned cnt,
        input int unsigned lanes
    );
        return (order == LANE_HIGH_FIRST) ? (lanes - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/flash_word_fifo.sv
// Word buffer for the flash capture path. DEPTH need not be a power of two.
//   clock, reset_n : single clock, asynchronous active-low reset
//   push, wr_data  : store wr_data at the tail (caller guarantees space or
//                    a simultaneous pop)
//   pop            : discard the head word (caller guarantees non-empty)
//   flush          : synchronous empty, takes priority over push/pop
//   head           : word at the head
//   level, full    : words held, level == DEPTH
module flash_word_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 wr_data,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full
);

    localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

    always_comb begin
        head = mem[rd_ptr];
        full = (level == LVW'(DEPTH));
    end

endmodule

// File: rtl/flash_word_unpacker.sv
// Captures full flash read words and presents each one as LANES lanes of
// N/LANES bits over a valid/ready handshake, in a per-word selectable order.
//   clock, reset_n : single clock, asynchronous active-low reset
//   read_data      : flash word, qualified by the one-cycle data_valid strobe
//   clear          : synchronous flush of buffer, lane counter and overflow
//   lane_order     : 0 = lane 0 first, 1 = top lane first (sampled per word)
//   out_ready      : consumer accepts the current lane
//   out_data       : current lane of the head word, valid with out_valid
//   lane_index     : physical lane number being presented
//   last_lane      : current lane is the final one of its word
//   in_ready       : buffer has room
//   level          : words held
//   overflow       : sticky, a word arrived with no room and was dropped
module flash_word_unpacker
    import flash_capture_pkg::*;
#(
    parameter int unsigned N     = 32,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [N-1:0]                 read_data,
    input  logic                         data_valid,
    input  logic                         clear,
    input  logic                         lane_order,
    input  logic                         out_ready,
    output logic [N/LANES-1:0]           out_data,
    output logic                         out_valid,
    output logic [$clog2(LANES)-1:0]     lane_index,
    output logic                         last_lane,
    output logic                         in_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow
);

    localparam int unsigned LW = N / LANES;
    localparam int unsigned CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST_CNT = CW'(LANES - 1);

    logic [N-1:0]  head;
    logic          full;
    logic [CW-1:0] lane_cnt;
    lane_order_t   order_q;
    lane_order_t   eff_order;
    logic          accept;
    logic          pop;
    logic          push;
    logic          drop;
    int unsigned   phys;

    flash_word_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop && !clear),
        .flush   (clear),
        .wr_data (read_data),
        .head    (head),
        .level   (level),
        .full    (full)
    );

    always_comb begin
        out_valid = (level != '0);
        in_ready  = !full;
        accept    = out_valid && out_ready;
        pop       = accept && (lane_cnt == LAST_CNT);
        // A full buffer still takes a word when the head leaves this cycle.
        push      = data_valid && !clear && (!full || pop);
        drop      = data_valid && !clear && full && !pop;
        // Order is sampled on the first lane, then held for the rest of the word.
        eff_order = (lane_cnt == '0) ? lane_order_t'(lane_order) : order_q;
        phys      = lane_select(eff_order, 32'(lane_cnt), LANES);
        out_data  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (phys == i) begin
                out_data = head[i*LW +: LW];
            end
        end
        lane_index = CW'(phys);
        last_lane  = out_valid && (lane_cnt == LAST_CNT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_cnt <= '0;
            order_q  <= LANE_LOW_FIRST;
            overflow <= 1'b0;
        end else begin
            order_q <= eff_order;
            if (clear) begin
                lane_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (accept) begin
                    lane_cnt <= pop ? '0 : lane_cnt + 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule
